// File: rtl/alu_bcd_formatter.sv
// alu_bcd_formatter
//   Sequential binary-to-BCD formatter for the calculator datapath. On a start
//   handshake it captures the ALU result (sign-corrected for subtraction) and
//   the remainder. It converts both with parallel shift-add-3 (double-dabble)
//   engines over 2*WIDTH cycles. It then holds the signed-magnitude BCD digits
//   until the consumer acknowledges.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-high, highest priority
//   start_i    capture request, honoured only while ready_o=1
//   fct_i      ALU function: 00 add, 01 sub, 10 mul, 11 div
//   res_i      ALU result (2*WIDTH bits, two's complement wrap for sub)
//   rem_i      ALU remainder (2*WIDTH bits)
//   ack_i      consumer acknowledge of valid_o
//   ready_o    high in IDLE
//   valid_o    high in DONE until ack_i
//   bcd_res_o  BCD magnitude of result, digit 0 in [3:0]
//   bcd_rem_o  BCD value of remainder
//   neg_o      result is negative (sub with borrow)

module alu_bcd_formatter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            fct_i,
    input  logic [2*WIDTH-1:0]    res_i,
    input  logic [2*WIDTH-1:0]    rem_i,
    input  logic                  ack_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_res_o,
    output logic [4*DIGITS-1:0]   bcd_rem_o,
    output logic                  neg_o
);

    localparam int BW = 2 * WIDTH;
    localparam int DW = 4 * DIGITS;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   res_bin;
    logic [BW-1:0]   rem_bin;
    logic [DW-1:0]   res_bcd;
    logic [DW-1:0]   rem_bcd;
    logic            neg_q;

    logic            cap_neg;
    logic [BW-1:0]   cap_mag;
    logic [DW-1:0]   res_step;
    logic [DW-1:0]   rem_step;

    // One double-dabble step on the BCD half: add 3 to every digit >= 5,
    // then shift left, pulling in the next binary MSB.
    function automatic logic [DW-1:0] dabble(input logic [DW-1:0] bcd,
                                             input logic          bit_in);
        logic [DW-1:0] adj;
        adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[DW-2:0], bit_in};
    endfunction

    always_comb begin
        cap_neg  = (fct_i == 2'b01) && res_i[BW-1];
        cap_mag  = cap_neg ? (~res_i + BW'(1)) : res_i;
        res_step = dabble(res_bcd, res_bin[BW-1]);
        rem_step = dabble(rem_bcd, rem_bin[BW-1]);
    end

    assign ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            res_bin   <= '0;
            rem_bin   <= '0;
            res_bcd   <= '0;
            rem_bcd   <= '0;
            neg_q     <= 1'b0;
            valid_o   <= 1'b0;
            neg_o     <= 1'b0;
            bcd_res_o <= '0;
            bcd_rem_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        res_bin <= cap_mag;
                        rem_bin <= rem_i;
                        res_bcd <= '0;
                        rem_bcd <= '0;
                        neg_q   <= cap_neg;
                        cnt     <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    res_bcd <= res_step;
                    rem_bcd <= rem_step;
                    res_bin <= res_bin << 1;
                    rem_bin <= rem_bin << 1;
                    cnt     <= cnt + CW'(1);
                    // Final step: publish the freshly stepped digits directly so
                    // the outputs appear on the same edge that enters DONE.
                    if (cnt == LAST_STEP) begin
                        bcd_res_o <= res_step;
                        bcd_rem_o <= rem_step;
                        neg_o     <= neg_q;
                        valid_o   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bcd_formatter.sv
// Directed testbench for alu_bcd_formatter (WIDTH=8, DIGITS=5).
module tb_alu_bcd_formatter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  fct;
    logic [15:0] res;
    logic [15:0] rem;
    logic        ack;
    logic        ready;
    logic        valid;
    logic [19:0] bcd_res;
    logic [19:0] bcd_rem;
    logic        neg;

    int n_checks = 0;
    int n_pass   = 0;

    alu_bcd_formatter #(.WIDTH(8), .DIGITS(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .fct_i     (fct),
        .res_i     (res),
        .rem_i     (rem),
        .ack_i     (ack),
        .ready_o   (ready),
        .valid_o   (valid),
        .bcd_res_o (bcd_res),
        .bcd_rem_o (bcd_rem),
        .neg_o     (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion, scramble the inputs after capture, wait for valid,
    // then check latency and the formatted outputs.
    task automatic convert(input string tag, input logic [1:0] f, input logic [15:0] r,
                           input logic [15:0] m, input logic [19:0] exp_res,
                           input logic [19:0] exp_rem, input logic exp_neg);
        int n;
        fct = f; res = r; rem = m; start = 1'b1;
        tick();
        start = 1'b0;
        fct = ~f; res = ~r; rem = ~m;
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd16);
        check({tag, "_res"}, {12'd0, bcd_res}, {12'd0, exp_res});
        check({tag, "_rem"}, {12'd0, bcd_rem}, {12'd0, exp_rem});
        check({tag, "_neg"}, {31'd0, neg}, {31'd0, exp_neg});
    endtask

    task automatic acknowledge(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ack_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_ack_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int seen_valid;
        rst = 1'b1; start = 1'b0; ack = 1'b0; fct = 2'b00; res = '0; rem = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_res",   {12'd0, bcd_res}, 32'd0);
        check("rst_rem",   {12'd0, bcd_rem}, 32'd0);
        check("rst_neg",   {31'd0, neg}, 32'd0);

        convert("add300", 2'b00, 16'd300,   16'd0, 20'h00300, 20'h00000, 1'b0); acknowledge("add300");
        check("persist_res", {12'd0, bcd_res}, 32'h00300);
        convert("sub7",   2'b01, 16'hFFF9,  16'd0, 20'h00007, 20'h00000, 1'b1); acknowledge("sub7");
        convert("sub255", 2'b01, 16'hFF01,  16'd0, 20'h00255, 20'h00000, 1'b1); acknowledge("sub255");
        convert("mul",    2'b10, 16'd65025, 16'd0, 20'h65025, 20'h00000, 1'b0); acknowledge("mul");
        convert("addmax", 2'b00, 16'hFFFF,  16'd0, 20'h65535, 20'h00000, 1'b0); acknowledge("addmax");
        convert("submin", 2'b01, 16'h8000,  16'd0, 20'h32768, 20'h00000, 1'b1); acknowledge("submin");
        convert("div",    2'b11, 16'd28,    16'd4, 20'h00028, 20'h00004, 1'b0); acknowledge("div");
        convert("div0",   2'b11, 16'd0,     16'd0, 20'h00000, 20'h00000, 1'b0); acknowledge("div0");
        convert("divbig", 2'b11, 16'd999,   16'd59999, 20'h00999, 20'h59999, 1'b0);

        // Held in DONE: start and a new value must be ignored while ack is low.
        start = 1'b1; fct = 2'b00; res = 16'd1234; rem = 16'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'd0, valid}, 32'd1);
            check("hold_ready", {31'd0, ready}, 32'd0);
            check("hold_res",   {12'd0, bcd_res}, 32'h00999);
            check("hold_rem",   {12'd0, bcd_rem}, 32'h59999);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        check("hs_valid", {31'd0, valid}, 32'd0);
        check("hs_ready", {31'd0, ready}, 32'd1);
        check("hs_res",   {12'd0, bcd_res}, 32'h00999);
        tick();
        check("hs_noq_ready", {31'd0, ready}, 32'd1);
        convert("newval", 2'b00, 16'd1234, 16'd0, 20'h01234, 20'h00000, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;

        // Reset on the 8th conversion step.
        fct = 2'b10; res = 16'd4321; rem = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ready", {31'd0, ready}, 32'd1);
        check("mid_valid", {31'd0, valid}, 32'd0);
        check("mid_res",   {12'd0, bcd_res}, 32'd0);
        check("mid_rem",   {12'd0, bcd_rem}, 32'd0);
        check("mid_neg",   {31'd0, neg}, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) seen_valid = 1;
        end
        check("mid_no_pulse", seen_valid, 32'd0);
        convert("after_rst", 2'b01, 16'hFFFF, 16'd0, 20'h00001, 20'h00000, 1'b1);
        acknowledge("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
